dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the word-address width (1024-word data memory).
REQ-002 Parameter DATA_W, default 32, SHALL set the data width.
REQ-003 clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  in  2  SHALL carry one access request per requester; bit 0 is CPU, bit 1 is debug/DMA.
REQ-006 we  in  2  SHALL select the access type per requester: 1 = write, 0 = read.
REQ-007 addr  in  2*ADDR_W  SHALL carry the word addresses; requester n uses slice [n*ADDR_W +: ADDR_W].
REQ-008 wdata  in  2*DATA_W  SHALL carry the write data, sliced the same way as addr.
REQ-009 gnt  out  2  SHALL be a one-hot, one-cycle pulse marking acceptance of a request.
REQ-010 rvalid  out  2  SHALL be a one-hot, one-cycle pulse marking read data valid for a requester.
REQ-011 rdata  out  DATA_W  SHALL be the read data; it is meaningful only when rvalid is nonzero.
REQ-012 mem_en, mem_we  out  1 each  SHALL be the memory enable and write strobe.
REQ-013 mem_addr  out  ADDR_W  and mem_wdata  out  DATA_W  SHALL be the memory address and write data.
REQ-014 mem_rdata  in  DATA_W  SHALL be the synchronous memory read data, valid one clock after mem_en with mem_we=0.
REQ-015 busy  out  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, ISSUE and RDATA.
REQ-017 IDLE with req!=0 SHALL select an owner, latch that owner's we/addr/wdata, and move to ISSUE; with req=0 it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: with both bits of req set, the requester other than last_owner wins; a single request always wins.
REQ-019 In ISSUE, mem_en=1, mem_we=latched we, mem_addr and mem_wdata SHALL equal the latched values, and gnt[owner]=1 for exactly this cycle.
REQ-020 ISSUE SHALL go to IDLE for a write and to RDATA for a read.
REQ-021 In RDATA, rvalid[owner]=1 and rdata=mem_rdata for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-022 Outside ISSUE, mem_en and mem_we SHALL be 0; gnt and rvalid SHALL be 0 except as stated in REQ-019 and REQ-021.
REQ-023 Latency SHALL be: write, gnt 1 cycle after req is sampled in IDLE; read, rvalid 2 cycles after req is sampled. Per-access occupancy SHALL be 2 cycles for a write and 3 for a read.
REQ-024 last_owner SHALL update to the owner on the IDLE->ISSUE transition.
REQ-025 A requester SHALL hold req and its fields stable until gnt; deasserting req while the FSM is in IDLE withdraws it with no memory access.
REQ-026 Request changes after the latch point SHALL NOT affect the access in progress.
REQ-027 A requester that keeps req high after gnt SHALL be treated as a new request and re-arbitrated in the next IDLE cycle.
REQ-028 No memory access SHALL ever be issued for a requester whose req was low when sampled in IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, last_owner=1 (so CPU wins the first tie), and gnt=0, rvalid=0, mem_en=0, mem_we=0, busy=0.
REQ-030 mem_addr, mem_wdata, rdata and the latched fields SHALL reset to 0.
REQ-031 A reset during ISSUE or RDATA SHALL abort the access; no gnt or rvalid pulse is produced after deassertion for the aborted access.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, RDATA=2'd2) and the requester index constants REQ_CPU=0 and REQ_DBG=1.
REQ-033 The round-robin selector SHALL be one combinational sub-module, rr_pick2 (inputs req[1:0] and last_owner; output owner plus valid); the rest stays flat.

Verification
REQ-034 CPU write: req=01, we=01, addr0=10'd5, wdata0=32'hDEAD_BEEF -> next cycle gnt=01, mem_en=1, mem_we=1, mem_addr=5; busy low one cycle later.
REQ-035 CPU read of the same address: req=01, we=00, addr0=5 -> gnt=01 at +1, then rvalid=01 and rdata=32'hDEAD_BEEF at +2.
REQ-036 Both requesters held continuously after reset -> grants alternate 01, 10, 01, 10; neither requester is granted twice in a row.
REQ-037 Simultaneous reads, addr0=1022 and addr1=0 -> CPU served first with rvalid=01, then debug with rvalid=10; rdata matches the memory model each time.
REQ-038 rst_n pulsed low during RDATA -> rvalid stays 0, FSM is in IDLE, and the next request is granted normally with CPU winning a tie.
REQ-039 req=10 raised for one cycle and dropped while the FSM is busy serving the CPU -> no debug gnt and no memory access issued for the debug port.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding,
// requester index constants and a one-hot helper.
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RDATA = 2'd2
   } state_t;

   localparam int REQ_CPU = 0;
   localparam int REQ_DBG = 1;

   // Requester index to its one-hot position on gnt/rvalid.
   function automatic logic [1:0] onehot2(input logic idx);
      return 2'b01 << idx;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// master: requesters drive req/we/addr/wdata; slave: arbiter drives gnt/rvalid/rdata.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);

   logic [1:0]          req;
   logic [1:0]          we;
   logic [2*ADDR_W-1:0] addr;
   logic [2*DATA_W-1:0] wdata;
   logic [1:0]          gnt;
   logic [1:0]          rvalid;
   logic [DATA_W-1:0]   rdata;

   modport master (
      output req, we, addr, wdata,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output gnt, rvalid, rdata
   );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin selector.
// in: req[1:0], last_owner; out: owner index, valid (any request).
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_owner,
   output logic       owner,
   output logic       valid
);

   logic both;

   assign both = &req;

   always_comb begin
      valid = |req;
      owner = 1'(REQ_CPU);
      unique case (1'b1)
         both:                  owner = ~last_owner;
         (req == 2'b10):        owner = 1'(REQ_DBG);
         default:               owner = 1'(REQ_CPU);
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates CPU and debug/DMA access to one synchronous data memory.
// in: clk, rst_n, bus (slave), mem_rdata; out: mem_en/we/addr/wdata, busy.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   dmem_arbiter_if.slave     bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t              state;
   state_t              nxt;
   logic                last_owner;
   logic                owner_q;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                pick_owner;
   logic                pick_valid;
   logic                take;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   rr_pick2 u_pick (
      .req        (bus.req),
      .last_owner (last_owner),
      .owner      (pick_owner),
      .valid      (pick_valid)
   );

   // Request is only sampled in IDLE; later changes cannot disturb it.
   assign take      = (state == IDLE) && pick_valid;
   assign sel_addr  = pick_owner ? bus.addr[REQ_DBG*ADDR_W +: ADDR_W]
                                 : bus.addr[REQ_CPU*ADDR_W +: ADDR_W];
   assign sel_wdata = pick_owner ? bus.wdata[REQ_DBG*DATA_W +: DATA_W]
                                 : bus.wdata[REQ_CPU*DATA_W +: DATA_W];

   // State register and request latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
      end else begin
         state <= nxt;
         if (take) begin
            last_owner <= pick_owner;
            owner_q    <= pick_owner;
            we_q       <= bus.we[pick_owner];
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    nxt = pick_valid ? ISSUE : IDLE;
         ISSUE:   nxt = we_q ? IDLE : RDATA;
         RDATA:   nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign busy      = (state != IDLE);

   // Outputs: strobes exist only in ISSUE/RDATA.
   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      bus.gnt    = 2'b00;
      bus.rvalid = 2'b00;
      bus.rdata  = '0;
      unique case (state)
         ISSUE: begin
            mem_en  = 1'b1;
            mem_we  = we_q;
            bus.gnt = onehot2(owner_q);
         end
         RDATA: begin
            bus.rvalid = onehot2(owner_q);
            bus.rdata  = mem_rdata;
         end
         default: begin
            mem_en = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a scoreboard of expected
// memory accesses and read returns, plus a behavioural memory.
module tb_dmem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          mem_en;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;

   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   typedef struct {
      logic          owner;
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } acc_t;

   typedef struct {
      logic [1:0]    rv;
      logic [DW-1:0] data;
   } rd_t;

   acc_t          acc_q[$];
   rd_t           rd_q[$];
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] ref_mem [1024];
   int            compared = 0;
   int            mismatched = 0;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every memory access and read return must be expected.
   acc_t ea;
   rd_t  er;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_en) begin
            if (acc_q.size() == 0) begin
               compared++;
               mismatched++;
               $error("FAIL sb_acc: observed access addr %0h expected none",
                      mem_addr);
            end else begin
               ea = acc_q.pop_front();
               chk("sb_gnt", 64'(bus.gnt), ea.owner ? 64'h2 : 64'h1);
               chk("sb_we", 64'(mem_we), 64'(ea.we));
               chk("sb_addr", 64'(mem_addr), 64'(ea.addr));
               if (ea.we) chk("sb_wdata", 64'(mem_wdata), 64'(ea.wdata));
            end
         end
         if (bus.rvalid != 2'b00) begin
            if (rd_q.size() == 0) begin
               compared++;
               mismatched++;
               $error("FAIL sb_rd: observed rvalid %0h expected none",
                      bus.rvalid);
            end else begin
               er = rd_q.pop_front();
               chk("sb_rvalid", 64'(bus.rvalid), 64'(er.rv));
               chk("sb_rdata", 64'(bus.rdata), 64'(er.data));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_acc(input logic o, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
      acc_t e;
      e.owner = o;
      e.we    = w;
      e.addr  = a;
      e.wdata = d;
      acc_q.push_back(e);
      if (w) ref_mem[a] = d;
   endtask

   task automatic push_rd(input logic [1:0] rv, input logic [AW-1:0] a);
      rd_t e;
      e.rv   = rv;
      e.data = ref_mem[a];
      rd_q.push_back(e);
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic single_write(input logic o, input logic [AW-1:0] a,
                               input logic [DW-1:0] d);
      bus.req = o ? 2'b10 : 2'b01;
      bus.we  = bus.req;
      bus.addr[o*AW +: AW]  = a;
      bus.wdata[o*DW +: DW] = d;
      push_acc(o, 1'b1, a, d);
      tick();
      chk("wr_gnt", 64'(bus.gnt), o ? 64'h2 : 64'h1);
      bus.req = 2'b00;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req   = 2'b00;
      bus.we    = 2'b00;
      bus.addr  = '0;
      bus.wdata = '0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_gnt", 64'(bus.gnt), 64'h0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
      chk("rst_mem_en", 64'(mem_en), 64'h0);
      chk("rst_mem_we", 64'(mem_we), 64'h0);
      chk("rst_mem_addr", 64'(mem_addr), 64'h0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'h0);
      chk("rst_rdata", 64'(bus.rdata), 64'h0);
      rst_n = 1'b1;

      // CPU write of DEADBEEF to word 5
      bus.req   = 2'b01;
      bus.we    = 2'b01;
      bus.addr  = {10'd0, 10'd5};
      bus.wdata = {32'd0, 32'hDEAD_BEEF};
      push_acc(1'b0, 1'b1, 10'd5, 32'hDEAD_BEEF);
      tick();
      chk("w_gnt", 64'(bus.gnt), 64'h1);
      chk("w_mem_en", 64'(mem_en), 64'h1);
      chk("w_mem_we", 64'(mem_we), 64'h1);
      chk("w_mem_addr", 64'(mem_addr), 64'd5);
      chk("w_busy", 64'(busy), 64'h1);
      bus.req = 2'b00;
      tick();
      chk("w_busy_done", 64'(busy), 64'h0);
      chk("w_mem_en_done", 64'(mem_en), 64'h0);

      // CPU read back of word 5
      bus.req = 2'b01;
      bus.we  = 2'b00;
      push_acc(1'b0, 1'b0, 10'd5, '0);
      push_rd(2'b01, 10'd5);
      tick();
      chk("r_gnt", 64'(bus.gnt), 64'h1);
      chk("r_mem_we", 64'(mem_we), 64'h0);
      bus.req = 2'b00;
      tick();
      chk("r_rvalid", 64'(bus.rvalid), 64'h1);
      chk("r_rdata", 64'(bus.rdata), 64'hDEAD_BEEF);
      chk("r_gnt_low", 64'(bus.gnt), 64'h0);
      tick();
      chk("r_busy_done", 64'(busy), 64'h0);
      chk("r_rvalid_done", 64'(bus.rvalid), 64'h0);

      // Preload words used by the dual-read step
      single_write(1'b0, 10'd1022, 32'h1111_2222);
      single_write(1'b1, 10'd0, 32'hA5A5_0F0F);

      // Both requesters held: grants must alternate starting with CPU
      pulse_reset();
      bus.req   = 2'b11;
      bus.we    = 2'b11;
      bus.addr  = {10'd200, 10'd100};
      bus.wdata = {32'h0000_BBBB, 32'h0000_AAAA};
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push_acc(1'b0, 1'b1, 10'd100, 32'h0000_AAAA);
         else            push_acc(1'b1, 1'b1, 10'd200, 32'h0000_BBBB);
      end
      for (int i = 0; i < 7; i++) begin
         tick();
         if (i % 2 == 0)
            chk("rr_gnt", 64'(bus.gnt), (i % 4 == 0) ? 64'h1 : 64'h2);
         else
            chk("rr_gap", 64'(bus.gnt), 64'h0);
      end
      bus.req = 2'b00;
      tick();
      tick();
      chk("rr_busy_done", 64'(busy), 64'h0);

      // Simultaneous reads at 1022 (CPU) and 0 (debug)
      pulse_reset();
      bus.req  = 2'b11;
      bus.we   = 2'b00;
      bus.addr = {10'd0, 10'd1022};
      push_acc(1'b0, 1'b0, 10'd1022, '0);
      push_rd(2'b01, 10'd1022);
      push_acc(1'b1, 1'b0, 10'd0, '0);
      push_rd(2'b10, 10'd0);
      tick();
      chk("dr_gnt_cpu", 64'(bus.gnt), 64'h1);
      bus.req = 2'b10;
      tick();
      chk("dr_rv_cpu", 64'(bus.rvalid), 64'h1);
      chk("dr_rd_cpu", 64'(bus.rdata), 64'h1111_2222);
      tick();
      chk("dr_idle", 64'(busy), 64'h0);
      tick();
      chk("dr_gnt_dbg", 64'(bus.gnt), 64'h2);
      bus.req = 2'b00;
      tick();
      chk("dr_rv_dbg", 64'(bus.rvalid), 64'h2);
      chk("dr_rd_dbg", 64'(bus.rdata), 64'hA5A5_0F0F);
      tick();
      chk("dr_busy_done", 64'(busy), 64'h0);

      // Reset asserted while in RDATA aborts the read
      bus.req  = 2'b01;
      bus.we   = 2'b00;
      bus.addr = {10'd0, 10'd5};
      push_acc(1'b0, 1'b0, 10'd5, '0);
      tick();
      chk("ab_gnt", 64'(bus.gnt), 64'h1);
      bus.req = 2'b00;
      tick();
      rst_n = 1'b0;
      #1;
      chk("ab_rvalid", 64'(bus.rvalid), 64'h0);
      chk("ab_busy", 64'(busy), 64'h0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("ab_rvalid_after", 64'(bus.rvalid), 64'h0);
      chk("ab_busy_after", 64'(busy), 64'h0);
      bus.req   = 2'b11;
      bus.we    = 2'b11;
      bus.addr  = {10'd301, 10'd300};
      bus.wdata = {32'h0000_0302, 32'h0000_0301};
      push_acc(1'b0, 1'b1, 10'd300, 32'h0000_0301);
      push_acc(1'b1, 1'b1, 10'd301, 32'h0000_0302);
      tick();
      chk("ab_tie_cpu", 64'(bus.gnt), 64'h1);
      bus.req = 2'b10;
      tick();
      tick();
      chk("ab_then_dbg", 64'(bus.gnt), 64'h2);
      bus.req = 2'b00;
      tick();
      chk("ab_busy_done", 64'(busy), 64'h0);

      // Debug pulse while CPU read is in flight is never served
      bus.req  = 2'b01;
      bus.we   = 2'b00;
      bus.addr = {10'd7, 10'd1022};
      push_acc(1'b0, 1'b0, 10'd1022, '0);
      push_rd(2'b01, 10'd1022);
      tick();
      chk("dp_gnt_cpu", 64'(bus.gnt), 64'h1);
      bus.req = 2'b10;
      tick();
      chk("dp_rv_cpu", 64'(bus.rvalid), 64'h1);
      chk("dp_no_dbg_gnt", 64'(bus.gnt), 64'h0);
      bus.req = 2'b00;
      tick();
      chk("dp_idle", 64'(busy), 64'h0);
      chk("dp_no_mem_en", 64'(mem_en), 64'h0);
      tick();
      chk("dp_still_idle", 64'(busy), 64'h0);

      repeat (2) tick();
      chk("acc_q_empty", 64'(acc_q.size()), 64'h0);
      chk("rd_q_empty", 64'(rd_q.size()), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
